dcache_wb_ctrl: RTL

Parametrised write-back, write-allocate, direct-mapped L1 data cache with a multi-beat refill/write-back state machine. It sits between the MEM stage (address, read/write strobes, store data) and a word-wide backing-memory port. It is the successor to the single-cycle combinational data caches: misses cost real cycles, the block drives a stall, dirty lines are written back, and a whole-cache flush and hit/miss counters are provided.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_wb_ctrl_if.sv | 32 +++
 rtl/dcache_array.sv | 56 +++++
 rtl/dcache_wb_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the write-back L1 data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WBACK, REFILL, FLUSH} state_e;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int wsel_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int lines, input int words);
    return addr_w - off_w(data_w) - wsel_w(words) - idx_w(lines);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_wb_ctrl_if.sv
// CPU-side, backing-memory and status signals of the data cache, grouped as one bus.
interface dcache_wb_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic              flush_req;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ack,
    input  cpu_rdata, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, flush_req, mem_rdata, mem_ack,
    output cpu_rdata, stall, flush_done, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_array.sv
// Direct-mapped line storage: combinational read of one word plus line metadata,
// synchronous single-word / metadata write; reset invalidates every line.
module dcache_array import dcache_pkg::*; #(
  parameter int   ADDR_W = 64,
  parameter int   DATA_W = 64,
  parameter int   LINES  = 16,
  parameter int   WORDS  = 4,
  localparam int  IDX_W  = idx_w(LINES),
  localparam int  WSEL_W = wsel_w(WORDS),
  localparam int  TAG_W  = tag_w(ADDR_W, DATA_W, LINES, WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [WSEL_W-1:0] rd_wsel_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [WSEL_W-1:0] wr_wsel_i,
  input  logic              data_we_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              meta_we_i,
  input  logic              wr_valid_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_wsel_i];

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  // Tags and data need no reset: nothing reads them while valid is clear.
  always_ff @(posedge clk) begin
    if (meta_we_i) tag_q[wr_idx_i] <= wr_tag_i;
    if (data_we_i) data_q[wr_idx_i][wr_wsel_i] <= wr_data_i;
  end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Write-back, write-allocate direct-mapped L1 D-cache: 0-cycle hits, multi-beat
// write-back/refill on a miss, whole-cache flush; stall holds the pipeline meanwhile.
module dcache_wb_ctrl import dcache_pkg::*; #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input logic            clk,
  input logic            reset,
  dcache_wb_ctrl_if.slave bus
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int WSEL_W = wsel_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINES, WORDS);

  state_e            state_q;
  logic [WSEL_W-1:0] beat_q;
  logic [IDX_W-1:0]  scan_q;
  logic              flush_done_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  logic [WSEL_W-1:0] cpu_wsel, rd_wsel;
  logic [IDX_W-1:0]  cpu_idx, rd_idx;
  logic [TAG_W-1:0]  cpu_tag, rd_tag, wr_tag;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              rd_valid, rd_dirty, access, hit, last_beat, beat_done;
  logic              data_we, meta_we, wr_valid, wr_dirty;
  logic              mem_req_c, mem_we_c, stall_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              unused_off;

  assign cpu_wsel   = bus.cpu_addr[OFF_W +: WSEL_W];
  assign cpu_idx    = bus.cpu_addr[OFF_W + WSEL_W +: IDX_W];
  assign cpu_tag    = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_off = ^bus.cpu_addr[OFF_W-1:0];

  assign access    = bus.cpu_rd | bus.cpu_wr;
  assign rd_idx    = (state_q == FLUSH) ? scan_q : cpu_idx;
  assign rd_wsel   = (state_q == IDLE) ? cpu_wsel : beat_q;
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign last_beat = &beat_q;
  assign beat_done = mem_req_c && bus.mem_ack;

  dcache_array #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx_i  (rd_idx),
    .rd_wsel_i (rd_wsel),
    .rd_valid_o(rd_valid),
    .rd_dirty_o(rd_dirty),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_idx_i  (rd_idx),
    .wr_wsel_i (rd_wsel),
    .data_we_i (data_we),
    .wr_data_i (wr_data),
    .meta_we_i (meta_we),
    .wr_valid_i(wr_valid),
    .wr_dirty_i(wr_dirty),
    .wr_tag_i  (wr_tag)
  );

  always_comb begin
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    data_we     = 1'b0;
    wr_data     = bus.cpu_wdata;
    meta_we     = 1'b0;
    wr_valid    = 1'b1;
    wr_dirty    = 1'b1;
    wr_tag      = rd_tag;
    stall_c     = (state_q != IDLE) || (access && (!hit || bus.flush_req));
    unique case (state_q)
      IDLE: begin
        if (!bus.flush_req && access && hit && bus.cpu_wr) begin
          data_we = 1'b1;
          meta_we = 1'b1;
        end
      end
      WBACK: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = {rd_tag, cpu_idx, beat_q, {OFF_W{1'b0}}};
        mem_wdata_c = rd_data;
      end
      REFILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {cpu_tag, cpu_idx, beat_q, {OFF_W{1'b0}}};
        if (bus.mem_ack) begin
          data_we  = 1'b1;
          wr_data  = bus.mem_rdata;
          meta_we  = last_beat;
          wr_dirty = 1'b0;
          wr_tag   = cpu_tag;
        end
      end
      FLUSH: begin
        // A dirty line is drained first, then revisited once as clean to be invalidated.
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
        if (rd_valid && rd_dirty) begin
          mem_req_c   = 1'b1;
          mem_we_c    = 1'b1;
          mem_addr_c  = {rd_tag, scan_q, beat_q, {OFF_W{1'b0}}};
          mem_wdata_c = rd_data;
          meta_we     = bus.mem_ack && last_beat;
        end else begin
          meta_we = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      scan_q       <= '0;
      flush_done_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (bus.flush_req) begin
            state_q <= FLUSH;
            scan_q  <= '0;
          end else if (access && hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else if (access) begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
            state_q    <= (rd_valid && rd_dirty) ? WBACK : REFILL;
          end
        end
        WBACK, REFILL: begin
          if (beat_done) begin
            beat_q <= beat_q + WSEL_W'(1);
            if (last_beat) state_q <= (state_q == WBACK) ? REFILL : IDLE;
          end
        end
        FLUSH: begin
          if (rd_valid && rd_dirty) begin
            if (beat_done) beat_q <= beat_q + WSEL_W'(1);
          end else if (scan_q == IDX_W'(LINES - 1)) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b1;
          end else begin
            scan_q <= scan_q + IDX_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.stall      = reset && stall_c;
  assign bus.cpu_rdata  = reset ? rd_data : '0;
  assign bus.mem_req    = reset && mem_req_c;
  assign bus.mem_we     = reset && mem_we_c;
  assign bus.mem_addr   = reset ? mem_addr_c : '0;
  assign bus.mem_wdata  = reset ? mem_wdata_c : '0;
  assign bus.flush_done = reset && flush_done_q;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;

endmodule
